uart_mch_ctrl: RTL

Multi-channel successor to the single-channel UART register controller. It synchronises NUM_CH asynchronous ready strobes and holds one pending request per channel. Requests are arbitrated round-robin into the shared TX FIFO, with per-channel sticky overflow flags and saturating loss counters. A handshaked launch FSM drives the UART transmitter, with a busy-acknowledge timeout.

---
 rtl/uart_ctrl_pkg.sv | 19 +
 rtl/uart_rdy_sync.sv | 26 ++
 rtl/uart_mch_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the multi-channel UART controller.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_t;

    localparam tx_state_t TX_STATE_RST = IDLE;
    localparam logic      STROBE_RST   = 1'b0;

    // Channel index width; a single channel still needs one select bit.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rdy_sync.sv
// Synchronises one asynchronous ready level and emits a registered rising-edge pulse.
module uart_rdy_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rdy_async,
    output logic rdy_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q   <= '0;
            prev_q   <= 1'b0;
            rdy_edge <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], rdy_async};
            prev_q   <= sync_q[SYNC_STAGES-1];
            rdy_edge <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/uart_mch_ctrl.sv
// Multi-channel UART controller: ready synchronisers, round-robin FIFO writer,
// per-channel loss tracking and a handshaked transmit launch FSM.
module uart_mch_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int SYNC_STAGES = 2,
    parameter  int CNT_W       = 8,
    parameter  int TIMEOUT     = 16,
    localparam int CH_W        = ch_width(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       In_rdy,
    input  logic                    FIFO_full,
    input  logic                    FIFO_empty,
    input  logic                    Tx_Busy,
    input  logic [NUM_CH-1:0]       Ovf_clr,
    output logic                    FIFO_send,
    output logic [CH_W-1:0]         FIFO_sel,
    output logic                    Send_TX,
    output logic [NUM_CH-1:0]       Overflow,
    output logic [NUM_CH*CNT_W-1:0] Ovf_cnt,
    output logic                    Tx_timeout,
    output tx_state_t               dbg_tx_state
);

    // Handshakes: a FIFO write (FIFO_send) is only issued for a grant made while
    // FIFO_full was low; a launch (Send_TX) is only issued while FIFO_empty and
    // Tx_Busy are both low, and Tx_Busy high acknowledges it.
    localparam int              TMR_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NUM_CH-1:0] edge_v;
    logic [NUM_CH-1:0] pending_q;
    logic [NUM_CH-1:0] grant_v;
    logic [NUM_CH-1:0] loss_v;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   gnt_ch;
    logic [CH_W-1:0]   idx_c;
    logic              gnt_valid;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic             ovf_q;
        logic [CNT_W-1:0] cnt_q;

        uart_rdy_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk       (clk),
            .rst_n     (rst_n),
            .rdy_async (In_rdy[i]),
            .rdy_edge  (edge_v[i])
        );

        // A loss in the same cycle as a clear leaves a count of one.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ovf_q <= 1'b0;
                cnt_q <= '0;
            end else if (loss_v[i]) begin
                ovf_q <= 1'b1;
                if (Ovf_clr[i])
                    cnt_q <= CNT_W'(1);
                else if (cnt_q != CNT_MAX)
                    cnt_q <= cnt_q + 1'b1;
            end else if (Ovf_clr[i]) begin
                ovf_q <= 1'b0;
                cnt_q <= '0;
            end
        end

        assign Overflow[i]                 = ovf_q;
        assign Ovf_cnt[i*CNT_W +: CNT_W]   = cnt_q;
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_ch    = '0;
        idx_c     = '0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx_c = CH_W'((int'(rr_ptr) + off) % NUM_CH);
            if (!gnt_valid && pending_q[idx_c]) begin
                gnt_valid = 1'b1;
                gnt_ch    = idx_c;
            end
        end
        if (FIFO_full) begin
            gnt_valid = 1'b0;
            gnt_ch    = '0;
        end
    end

    always_comb begin
        grant_v = '0;
        if (gnt_valid)
            grant_v[gnt_ch] = 1'b1;
    end

    assign loss_v = edge_v & pending_q & ~grant_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
            rr_ptr    <= '0;
            FIFO_send <= STROBE_RST;
            FIFO_sel  <= '0;
        end else begin
            pending_q <= (pending_q & ~grant_v) | edge_v;
            FIFO_send <= gnt_valid;
            FIFO_sel  <= gnt_valid ? gnt_ch : '0;
            if (gnt_valid)
                rr_ptr <= CH_W'((int'(gnt_ch) + 1) % NUM_CH);
        end
    end

    tx_state_t        state_q, state_nxt;
    logic [TMR_W-1:0] tmr_q, tmr_nxt;
    logic             launch, to_fire;

    always_comb begin
        state_nxt = state_q;
        tmr_nxt   = tmr_q;
        launch    = 1'b0;
        to_fire   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!FIFO_empty && !Tx_Busy) begin
                    state_nxt = LAUNCH;
                    launch    = 1'b1;
                end
            end
            LAUNCH: begin
                state_nxt = WAIT_BUSY;
                tmr_nxt   = '0;
            end
            WAIT_BUSY: begin
                if (Tx_Busy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
                    state_nxt = IDLE;
                    to_fire   = 1'b1;
                end else begin
                    tmr_nxt = tmr_q + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!Tx_Busy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= TX_STATE_RST;
            tmr_q      <= '0;
            Send_TX    <= STROBE_RST;
            Tx_timeout <= STROBE_RST;
        end else begin
            state_q    <= state_nxt;
            tmr_q      <= tmr_nxt;
            Send_TX    <= launch;
            Tx_timeout <= to_fire;
        end
    end

    assign dbg_tx_state = state_q;

endmodule
